ula_acumuladora: RTL and testbench

Parametrised, registered successor to the SAP-1 adder/subtractor. It sits between the A and B registers and the W bus: it latches operands on `start`, computes a WIDTH-bit result plus a four-bit flag set, and holds both in registers. The result is driven onto the shared bus only while `eu` is high. An optional serial multiplier adds a multi-cycle operation behind the same start/done handshake.

---
 rtl/ula_pkg.sv | 36 +++
 rtl/multiplicador_serial.sv | 49 ++++
 rtl/ula_acumuladora.sv | 148 ++++++++++++++
 tb/tb_ula_acumuladora.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ula_pkg.sv
// Shared definitions for the accumulating ALU: op codes, FSM states and flag bit positions.
package ula_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_ADC = 3'b010;
  localparam logic [2:0] OP_SBC = 3'b011;
  localparam logic [2:0] OP_INC = 3'b100;
  localparam logic [2:0] OP_DEC = 3'b101;
  localparam logic [2:0] OP_CMP = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int NUM_FLAGS = 4;
  localparam int FLAG_C    = 0;
  localparam int FLAG_Z    = 1;
  localparam int FLAG_N    = 2;
  localparam int FLAG_V    = 3;

  function automatic logic [NUM_FLAGS-1:0] make_flags(input logic c, input logic z,
                                                      input logic n, input logic v);
    logic [NUM_FLAGS-1:0] f;
    f         = '0;
    f[FLAG_C] = c;
    f[FLAG_Z] = z;
    f[FLAG_N] = n;
    f[FLAG_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/multiplicador_serial.sv
// Unsigned WIDTH x WIDTH shift-add multiplier, one step per cycle while passo is high.
// 'produto' is the combinational outcome of the current step, so the last step's value can be captured on the edge that completes it.
module multiplicador_serial #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               carga,
  input  logic               passo,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               fim,
  output logic [2*WIDTH-1:0] produto
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] mcand_reg;
  logic [WIDTH-1:0] hi_reg, hi_next;
  logic [WIDTH-1:0] lo_reg, lo_next;
  logic [CW-1:0]    count_reg;
  logic [WIDTH:0]   soma;

  // The low half starts as the multiplier and is consumed LSB first while product bits shift in from the top
  assign soma    = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, mcand_reg} : '0);
  assign hi_next = soma[WIDTH:1];
  assign lo_next = {soma[0], lo_reg[WIDTH-1:1]};
  assign produto = {hi_next, lo_next};
  assign fim     = passo && (count_reg == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      mcand_reg <= '0;
      hi_reg    <= '0;
      lo_reg    <= '0;
      count_reg <= '0;
    end else if (carga) begin
      mcand_reg <= a;
      hi_reg    <= '0;
      lo_reg    <= b;
      count_reg <= '0;
    end else if (passo) begin
      hi_reg    <= hi_next;
      lo_reg    <= lo_next;
      count_reg <= count_reg + 1'b1;
    end
  end

endmodule

// File: rtl/ula_acumuladora.sv
// Registered ALU with carry/zero/negative/overflow flags and a tri-state bus output.
// Defining ULA_MUL_EN adds a multi-cycle serial multiply on op 111; otherwise op 111 is a no-op.
module ula_acumuladora
  import ula_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             eu,
  output wire logic [WIDTH-1:0] s,
  output logic             busy,
  output logic             done,
  output logic             cf,
  output logic             zf,
  output logic             nf,
  output logic             vf
);

  state_t               state_reg, state_next;
  logic [WIDTH-1:0]     result_reg, result_next;
  logic [NUM_FLAGS-1:0] flags_reg, flags_next;

  logic [WIDTH-1:0]     op_b;
  logic                 cin;
  logic [WIDTH:0]       sum;
  logic [NUM_FLAGS-1:0] alu_flags;

`ifdef ULA_MUL_EN
  logic                 mul_load;
  logic                 mul_step;
  logic                 mul_fim;
  logic [2*WIDTH-1:0]   mul_prod;

  assign mul_load = start && (state_reg != ST_BUSY) && (op == OP_MUL);
  assign mul_step = (state_reg == ST_BUSY);

  multiplicador_serial #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .clr     (clr),
    .carga   (mul_load),
    .passo   (mul_step),
    .a       (a),
    .b       (b),
    .fim     (mul_fim),
    .produto (mul_prod)
  );

  assign busy = (state_reg == ST_BUSY);
`else
  assign busy = 1'b0;
`endif

  // Every arithmetic op is A + op_b + cin; subtracts invert B, INC/DEC use an implicit operand
  always_comb begin
    op_b = b;
    cin  = 1'b0;
    case (op)
      OP_SUB, OP_CMP: begin
        op_b = ~b;
        cin  = 1'b1;
      end
      OP_ADC: cin = flags_reg[FLAG_C];
      OP_SBC: begin
        op_b = ~b;
        cin  = flags_reg[FLAG_C];
      end
      OP_INC: begin
        op_b = '0;
        cin  = 1'b1;
      end
      OP_DEC: op_b = '1;
      default: ;
    endcase
  end

  assign sum = {1'b0, a} + {1'b0, op_b} + {{WIDTH{1'b0}}, cin};

  assign alu_flags = make_flags(sum[WIDTH],
                                (sum[WIDTH-1:0] == '0),
                                sum[WIDTH-1],
                                (a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]));

  always_comb begin
    state_next  = state_reg;
    result_next = result_reg;
    flags_next  = flags_reg;
    case (state_reg)
      // DONE accepts a new request exactly like IDLE, giving one op per cycle
      ST_IDLE, ST_DONE: begin
        state_next = ST_IDLE;
        if (start) begin
          state_next = ST_DONE;
          case (op)
            OP_CMP: flags_next = alu_flags;
            OP_MUL: begin
`ifdef ULA_MUL_EN
              state_next = ST_BUSY;
`endif
            end
            default: begin
              result_next = sum[WIDTH-1:0];
              flags_next  = alu_flags;
            end
          endcase
        end
      end
`ifdef ULA_MUL_EN
      ST_BUSY: begin
        if (mul_fim) begin
          state_next  = ST_DONE;
          result_next = mul_prod[WIDTH-1:0];
          flags_next  = make_flags(|mul_prod[2*WIDTH-1:WIDTH],
                                   (mul_prod[WIDTH-1:0] == '0),
                                   mul_prod[WIDTH-1],
                                   |mul_prod[2*WIDTH-1:WIDTH]);
        end
      end
`endif
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_reg  <= ST_IDLE;
      result_reg <= '0;
      flags_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      result_reg <= result_next;
      flags_reg  <= flags_next;
    end
  end

  assign done = (state_reg == ST_DONE);
  assign cf   = flags_reg[FLAG_C];
  assign zf   = flags_reg[FLAG_Z];
  assign nf   = flags_reg[FLAG_N];
  assign vf   = flags_reg[FLAG_V];

  assign s = eu ? result_reg : {WIDTH{1'bz}};

endmodule

// File: tb/tb_ula_acumuladora.sv
// Randomized self-checking bench for ula_acumuladora against an integer-arithmetic reference model.
// The bus is pulled up, so a released bus reads as all ones.
module tb_ula_acumuladora;
  import ula_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         clr, start, eu;
  logic [2:0]   op;
  logic [W-1:0] a, b;
  wire  [W-1:0] s_bus;
  logic         busy, done, cf, zf, nf, vf;

  for (genvar gi = 0; gi < W; gi++) begin : g_pull
    pullup (s_bus[gi]);
  end

  always #5 clk = ~clk;

  ula_acumuladora #(.WIDTH(W)) dut (
    .clk   (clk),
    .clr   (clr),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .eu    (eu),
    .s     (s_bus),
    .busy  (busy),
    .done  (done),
    .cf    (cf),
    .zf    (zf),
    .nf    (nf),
    .vf    (vf)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] m_res;
  logic         m_cf, m_zf, m_nf, m_vf;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".s"},  s_bus, eu ? m_res : 8'hFF);
    check({tag, ".cf"}, cf, m_cf);
    check({tag, ".zf"}, zf, m_zf);
    check({tag, ".nf"}, nf, m_nf);
    check({tag, ".vf"}, vf, m_vf);
  endtask

  // Reference model: plain integer arithmetic, carries/borrows and signed ranges
  task automatic model(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
    int ua, ub, sa, sb, c, u, t;
    logic [7:0] r;
    ua = x;
    ub = y;
    sa = $signed(x);
    sb = $signed(y);
    c  = m_cf ? 1 : 0;
    case (o)
      OP_ADD: begin u = ua + ub;           t = sa + sb;           m_cf = (u > 255); end
      OP_SUB: begin u = ua - ub;           t = sa - sb;           m_cf = (u >= 0);  end
      OP_ADC: begin u = ua + ub + c;       t = sa + sb + c;       m_cf = (u > 255); end
      OP_SBC: begin u = ua - ub - (1 - c); t = sa - sb - (1 - c); m_cf = (u >= 0);  end
      OP_INC: begin u = ua + 1;            t = sa + 1;            m_cf = (u > 255); end
      OP_DEC: begin u = ua - 1;            t = sa - 1;            m_cf = (u >= 0);  end
      OP_CMP: begin u = ua - ub;           t = sa - sb;           m_cf = (u >= 0);  end
      default: begin
`ifdef ULA_MUL_EN
        u     = ua * ub;
        r     = u[7:0];
        m_res = r;
        m_cf  = (u > 255);
        m_vf  = (u > 255);
        m_zf  = (r == 8'h00);
        m_nf  = r[7];
`endif
        return;
      end
    endcase
    r    = u[7:0];
    m_vf = (t > 127) || (t < -128);
    m_zf = (r == 8'h00);
    m_nf = r[7];
    if (o != OP_CMP) m_res = r;
  endtask

  // noise keeps start asserted with junk operands for the whole BUSY period
  task automatic run_op(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                        input logic e, input bit noise);
    int k;
    @(negedge clk);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    eu    = e;
    @(posedge clk);
    #1;
    model(o, x, y);
`ifdef ULA_MUL_EN
    if (o == OP_MUL) begin
      check("mul.busy_start", busy, 1);
      if (noise) begin
        op = OP_ADD;
        a  = 8'($urandom);
        b  = 8'($urandom);
      end else begin
        start = 1'b0;
      end
      k = 0;
      while (busy && k < W + 4) begin
        @(posedge clk);
        #1;
        k++;
      end
      start = 1'b0;
      check("mul.busy_cycles", k, W);
    end else begin
      start = 1'b0;
    end
`else
    start = 1'b0;
    if (noise) check("op.busy_nomul", busy, 0);
`endif
    check("op.done", done, 1);
    check("op.busy", busy, 0);
    check_outputs("op");
    $display("op=%0d a=%02h b=%02h eu=%0b -> s=%02h cf=%0b zf=%0b nf=%0b vf=%0b", o, x, y, e,
             s_bus, cf, zf, nf, vf);
  endtask

  task automatic idle(input int n, input logic e);
    @(negedge clk);
    start = 1'b0;
    eu    = e;
    repeat (n) @(posedge clk);
    #1;
    check("idle.done", done, 0);
    check("idle.busy", busy, 0);
    check_outputs("idle");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    clr   = 1'b1;
    start = 1'b0;
    eu    = 1'b1;
    op    = 3'b000;
    a     = '0;
    b     = '0;
    m_res = '0;
    m_cf  = 1'b0;
    m_zf  = 1'b0;
    m_nf  = 1'b0;
    m_vf  = 1'b0;
    #12;
    check("rst.s", s_bus, 8'h00);
    check("rst.flags", {cf, zf, nf, vf}, 4'b0000);
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    @(negedge clk);
    clr = 1'b0;

    // Signed overflow
    run_op(OP_ADD, 8'h7F, 8'h01, 1'b1, 1'b0);
    check("ovf.s", s_bus, 8'h80);
    check("ovf.nzvc", {nf, zf, vf, cf}, 4'b1010);

    // Borrow then back-to-back SBC consuming cf
    run_op(OP_SUB, 8'h05, 8'h05, 1'b1, 1'b0);
    check("sub.s", s_bus, 8'h00);
    check("sub.zc", {zf, cf}, 2'b11);
    run_op(OP_SBC, 8'h00, 8'h01, 1'b1, 1'b0);
    check("sbc.s", s_bus, 8'hFF);
    check("sbc.cn", {cf, nf}, 2'b01);

    // CMP leaves the result register alone
    run_op(OP_ADD, 8'h30, 8'h03, 1'b1, 1'b0);
    run_op(OP_CMP, 8'h10, 8'h20, 1'b1, 1'b0);
    check("cmp.s", s_bus, 8'h33);
    check("cmp.cn", {cf, nf}, 2'b01);

    // Bus release and re-drive while idle
    idle(1, 1'b0);
    check("bus.off", s_bus, 8'hFF);
    idle(1, 1'b1);
    check("bus.on", s_bus, 8'h33);
    idle(1, 1'b0);

    // Op 111, with a start held during BUSY that must be ignored
    run_op(OP_MUL, 8'h10, 8'h11, 1'b1, 1'b1);
`ifdef ULA_MUL_EN
    check("mul.s", s_bus, 8'h10);
    check("mul.cv", {cf, vf}, 2'b11);
`else
    check("nomul.s", s_bus, 8'h33);
`endif
    idle(1, 1'b1);

    // Randomized mix, including back-to-back ops, gaps and bus toggling
    for (int i = 0; i < 150; i++) begin
      logic [2:0] ro;
      ro = 3'($urandom_range(0, 7));
      run_op(ro, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2), 1'($urandom));
    end

    // Asynchronous clear in the middle of op 111
    run_op(OP_ADD, 8'h7F, 8'h01, 1'b1, 1'b0);
    @(negedge clk);
    start = 1'b1;
    op    = OP_MUL;
    a     = 8'hFF;
    b     = 8'hFF;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    clr = 1'b1;
    #1;
    check("clr.s", s_bus, 8'h00);
    check("clr.flags", {cf, zf, nf, vf}, 4'b0000);
    check("clr.busy", busy, 0);
    check("clr.done", done, 0);
    m_res = '0;
    m_cf  = 1'b0;
    m_zf  = 1'b0;
    m_nf  = 1'b0;
    m_vf  = 1'b0;
    @(negedge clk);
    clr = 1'b0;
    run_op(OP_DEC, 8'h80, 8'h00, 1'b1, 1'b0);
    idle(1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
